// File: rtl/calc_op_sequencer.sv
// Calculator front-end: conditions the op/go keys, latches operands, handshakes with the arithmetic unit.
// Optional macro CALC_KEY_DEBOUNCE_EN builds the per-key debounce counters.
module calc_op_sequencer #(
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                MAX10_CLK1_50,
  input  logic                rst,
  input  logic                key_op_n,
  input  logic                key_go_n,
  input  logic [DATA_W-1:0]   sw_a,
  input  logic [DATA_W-1:0]   sw_b,
  input  logic                unit_done,
  input  logic [2*DATA_W-1:0] unit_result,
  output logic [1:0]          op_sel,
  output logic [3:0]          cs,
  output logic                unit_start,
  output logic [DATA_W-1:0]   unit_a,
  output logic [DATA_W-1:0]   unit_b,
  output logic [2*DATA_W-1:0] result,
  output logic                result_valid,
  output logic                err,
  output logic                busy
);
  localparam int unsigned RES_W    = 2 * DATA_W;
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  OP_DIV   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  // Key conditioning: bit 1 = go, bit 0 = op; levels idle high (released)
  logic [1:0] key_raw;
  logic [1:0] sync1_q, sync2_q, acc_q, acc_d, evt_q;
  logic       go_evt, op_evt;

  assign key_raw = {key_go_n, key_op_n};
  assign go_evt  = evt_q[1];
  assign op_evt  = evt_q[0];

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      acc_q   <= 2'b11;
      evt_q   <= 2'b00;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      evt_q   <= acc_q & ~acc_d;
    end
  end

`ifdef CALC_KEY_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    acc_d    = acc_q;
    db_cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != acc_q[k]) begin
        if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) acc_d[k] = sync2_q[k];
        else db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) db_cnt_q <= '0;
    else     db_cnt_q <= db_cnt_d;
  end
`else
  always_comb acc_d = sync2_q;
`endif

  state_e              state_q, state_d;
  logic [1:0]          op_sel_q, op_sel_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                valid_q, valid_d, err_q, err_d, start_q, start_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                div_zero_c;

  assign div_zero_c = (op_sel_q == OP_DIV) && (b_q == '0);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_evt)      state_d = S_ISSUE;
        else if (op_evt) state_d = S_IDLE;
      end
      S_ISSUE: state_d = div_zero_c ? S_DONE : S_WAIT;
      S_WAIT:  if (unit_done || tmo_q == TMO_LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values; unit_start is registered so it lines up with ISSUE
  always_comb begin
    op_sel_d = op_sel_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    valid_d  = valid_q;
    err_d    = err_q;
    start_d  = 1'b0;
    tmo_d    = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_evt) begin
          a_d     = sw_a;
          b_d     = sw_b;
          valid_d = 1'b0;
          err_d   = 1'b0;
          start_d = !((op_sel_q == OP_DIV) && (sw_b == '0));
        end else if (op_evt) begin
          op_sel_d = op_sel_q + 2'd1;
          valid_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (div_zero_c) begin
          res_d   = '1;
          err_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (unit_done) begin
          res_d   = unit_result;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          res_d   = '1;
          err_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      op_sel_q <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      op_sel_q <= op_sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      start_q  <= start_d;
      tmo_q    <= tmo_d;
    end
  end

  assign op_sel       = op_sel_q;
  assign cs           = state_q;
  assign unit_start   = start_q;
  assign unit_a       = a_q;
  assign unit_b       = b_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign err          = err_q;
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
endmodule
